// File: rtl/lc3b_ctrl_pipe_pkg.sv
// LC-3b shared types: opcodes, ALU ops, the packed control word and the
// per-stage pipeline record carried by lc3b_ctrl_pipe.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add,
      alu_and,
      alu_not,
      alu_pass,
      alu_sll,
      alu_srl,
      alu_sra
   } lc3b_aluop;

   typedef struct packed {
      lc3b_opcode opcode;
      lc3b_aluop  aluop;
      logic       load_regfile;
      logic       load_cc;
      logic       load_pc;
      logic       mem_read;
      logic       mem_write;
      logic       mem_byte;
   } lc3b_control;

   localparam int unsigned CONTROL_WIDTH = $bits(lc3b_control);

   // All enables zero: a bubble never writes architectural state.
   localparam lc3b_control CTRL_NOP = '0;

   typedef struct packed {
      logic        valid;
      lc3b_control ctrl;
      lc3b_word    pc;
   } lc3b_stage_t;

endpackage

// File: rtl/lc3b_ctrl_pipe_sat_counter.sv
// Saturating accumulator: adds an INC_W-bit increment each cycle and
// clamps at all-ones instead of wrapping.
module lc3b_sat_counter #(
   parameter int unsigned W     = 16,
   parameter int unsigned INC_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [INC_W-1:0] inc,
   output logic [W-1:0]     count
);

   localparam int unsigned SW = ((W > INC_W) ? W : INC_W) + 1;
   localparam logic [SW-1:0] MAX = (SW'(1) << W) - SW'(1);

   logic [SW-1:0] sum;

   assign sum = SW'(count) + SW'(inc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (sum > MAX) begin
         count <= '1;
      end else begin
         count <= sum[W-1:0];
      end
   end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// In-order control-word/PC pipeline register chain with per-stage stall,
// flush, bubble injection at the stall boundary and saturating counters.
module lc3b_ctrl_pipe
   import lc3b_types::*;
#(
   parameter int unsigned STAGES = 4,
   parameter int unsigned CW     = CONTROL_WIDTH,
   parameter int unsigned PCW    = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [CW-1:0]         in_ctrl,
   input  logic [PCW-1:0]        in_pc,
   output logic                  in_ready,
   input  logic [STAGES-1:0]     stall_i,
   input  logic [STAGES-1:0]     flush_i,
   output logic [STAGES-1:0]     stage_valid_o,
   output logic [STAGES*CW-1:0]  stage_ctrl_o,
   output logic [STAGES*PCW-1:0] stage_pc_o,
   output logic [CNT_W-1:0]      bubble_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   localparam int unsigned FW = $clog2(STAGES + 1);
   localparam logic [CW-1:0] NOP_CW = CW'(CTRL_NOP);

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] inject;
   logic [FW-1:0]     flush_inc;

   // Hold is an OR-reduction from the tail; the running accumulator keeps
   // the chain free of self-referencing combinational feedback.
   always_comb begin
      logic acc;
      acc  = 1'b0;
      hold = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         acc                  = acc | stall_i[STAGES-1-i];
         hold[STAGES-1-i]     = acc;
      end
   end

   always_comb begin
      inject = '0;
      for (int unsigned i = 1; i < STAGES; i++) begin
         inject[i] = hold[i-1] & ~hold[i] & ~flush_i[i];
      end
   end

   always_comb begin
      flush_inc = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         flush_inc = flush_inc + FW'(flush_i[i] & stage_valid_o[i]);
      end
   end

   assign in_ready = ~hold[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic           v_q;
      logic [CW-1:0]  c_q;
      logic [PCW-1:0] p_q;

      if (k == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (!rst_n || flush_i[0]) begin
               v_q <= 1'b0;
               c_q <= NOP_CW;
               p_q <= '0;
            end else if (!hold[0]) begin
               v_q <= in_valid;
               c_q <= in_valid ? in_ctrl : NOP_CW;
               p_q <= in_pc;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk) begin
            if (!rst_n || flush_i[k] || (!hold[k] && hold[k-1])) begin
               v_q <= 1'b0;
               c_q <= NOP_CW;
               p_q <= '0;
            end else if (!hold[k]) begin
               v_q <= stage_valid_o[k-1];
               c_q <= stage_ctrl_o[(k-1)*CW +: CW];
               p_q <= stage_pc_o[(k-1)*PCW +: PCW];
            end
         end
      end

      assign stage_valid_o[k]          = v_q;
      assign stage_ctrl_o[k*CW +: CW]  = c_q;
      assign stage_pc_o[k*PCW +: PCW]  = p_q;
   end

   lc3b_sat_counter #(
      .W     (CNT_W),
      .INC_W (1)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (|inject),
      .count (bubble_cnt_o)
   );

   lc3b_sat_counter #(
      .W     (CNT_W),
      .INC_W (FW)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .count (flush_cnt_o)
   );

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Directed bench for lc3b_ctrl_pipe: reset, streaming, stall/bubble, last-stage
// freeze, flush priority and counter saturation (second instance with CNT_W=4).
module tb_lc3b_ctrl_pipe;
   import lc3b_types::*;

   localparam int unsigned S   = 4;
   localparam int unsigned CW  = CONTROL_WIDTH;
   localparam int unsigned PCW = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [CW-1:0]    in_ctrl;
   logic [PCW-1:0]   in_pc;
   logic [S-1:0]     stall;
   logic [S-1:0]     flush;

   logic             in_ready, in_ready_s;
   logic [S-1:0]     stage_valid, stage_valid_s;
   logic [S*CW-1:0]  stage_ctrl, stage_ctrl_s;
   logic [S*PCW-1:0] stage_pc, stage_pc_s;
   logic [15:0]      bubble_cnt, flush_cnt;
   logic [3:0]       bubble_cnt_s, flush_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lc3b_ctrl_pipe #(.STAGES(S), .CW(CW), .PCW(PCW), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .in_ready(in_ready), .stall_i(stall), .flush_i(flush),
      .stage_valid_o(stage_valid), .stage_ctrl_o(stage_ctrl), .stage_pc_o(stage_pc),
      .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
   );

   lc3b_ctrl_pipe #(.STAGES(S), .CW(CW), .PCW(PCW), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .in_ready(in_ready_s), .stall_i(stall), .flush_i(flush),
      .stage_valid_o(stage_valid_s), .stage_ctrl_o(stage_ctrl_s), .stage_pc_o(stage_pc_s),
      .bubble_cnt_o(bubble_cnt_s), .flush_cnt_o(flush_cnt_s)
   );

   function automatic logic [CW-1:0] ctrl_of(input logic [15:0] pc);
      logic [15:0] t;
      t = pc ^ 16'h0A5A;
      return t[CW-1:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_stage(input int unsigned k, input logic v, input logic [15:0] pc);
      string s;
      s = $sformatf("s%0d", k);
      check({s, ".valid"}, 64'(stage_valid[k]), 64'(v));
      check({s, ".pc"},    64'(stage_pc[k*PCW +: PCW]), 64'(pc));
      check({s, ".ctrl"},  64'(stage_ctrl[k*CW +: CW]), v ? 64'(ctrl_of(pc)) : 64'(0));
   endtask

   task automatic drive(input logic v, input logic [15:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_ctrl  = v ? ctrl_of(pc) : '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = '0;
      flush = '0;
      drive(1'b0, 16'h0);
      tick();
      tick();

      // Reset mid-stream
      rst_n = 1'b1;
      drive(1'b1, 16'h0080); tick();
      drive(1'b1, 16'h0082); tick();
      check_stage(0, 1'b1, 16'h0082);
      check_stage(1, 1'b1, 16'h0080);
      rst_n = 1'b0;
      tick();
      check("rst.valid", 64'(stage_valid), 64'(0));
      check("rst.ctrl",  64'(stage_ctrl),  64'(0));
      check("rst.pc",    64'(stage_pc),    64'(0));
      check("rst.bubble", 64'(bubble_cnt), 64'(0));
      check("rst.flush",  64'(flush_cnt),  64'(0));
      check("rst.ready",  64'(in_ready),   64'(1));

      // Streaming
      rst_n = 1'b1;
      drive(1'b1, 16'h0010); tick();
      check_stage(0, 1'b1, 16'h0010);
      drive(1'b1, 16'h0012); tick();
      drive(1'b1, 16'h0014); tick();
      drive(1'b1, 16'h0016); tick();
      check_stage(3, 1'b1, 16'h0010);
      check_stage(2, 1'b1, 16'h0012);
      check_stage(1, 1'b1, 16'h0014);
      check_stage(0, 1'b1, 16'h0016);
      check("stream.bubble", 64'(bubble_cnt), 64'(0));

      // Mid-pipe stall: bubbles enter stage 3
      stall = 4'b0100;
      drive(1'b1, 16'h0018);
      #1 check("stall2.ready", 64'(in_ready), 64'(0));
      tick();
      check_stage(3, 1'b0, 16'h0000);
      check("stall2.bubble1", 64'(bubble_cnt), 64'(1));
      tick();
      check_stage(0, 1'b1, 16'h0016);
      check_stage(1, 1'b1, 16'h0014);
      check_stage(2, 1'b1, 16'h0012);
      check_stage(3, 1'b0, 16'h0000);
      check("stall2.bubble2", 64'(bubble_cnt), 64'(2));
      check("stall2.bubble2_sat", 64'(bubble_cnt_s), 64'(2));
      stall = '0;
      tick();
      check_stage(0, 1'b1, 16'h0018);
      check_stage(1, 1'b1, 16'h0016);
      check_stage(2, 1'b1, 16'h0014);
      check_stage(3, 1'b1, 16'h0012);

      // Last-stage stall freezes everything, no bubbles
      stall = 4'b1000;
      drive(1'b1, 16'h001A);
      #1 check("stall3.ready", 64'(in_ready), 64'(0));
      repeat (3) tick();
      check_stage(0, 1'b1, 16'h0018);
      check_stage(3, 1'b1, 16'h0012);
      check("stall3.bubble", 64'(bubble_cnt), 64'(2));
      stall = '0;
      tick();
      check_stage(0, 1'b1, 16'h001A);
      check_stage(1, 1'b1, 16'h0018);
      check_stage(2, 1'b1, 16'h0016);
      check_stage(3, 1'b1, 16'h0014);

      // Flush beats stall; stall boundary still injects at stage 2
      flush = 4'b0011;
      stall = 4'b0010;
      drive(1'b1, 16'h001C);
      #1 check("flush.ready", 64'(in_ready), 64'(0));
      tick();
      flush = '0;
      stall = '0;
      check_stage(0, 1'b0, 16'h0000);
      check_stage(1, 1'b0, 16'h0000);
      check_stage(2, 1'b0, 16'h0000);
      check_stage(3, 1'b1, 16'h0016);
      check("flush.cnt", 64'(flush_cnt), 64'(2));
      check("flush.bubble", 64'(bubble_cnt), 64'(3));

      // Accepted input with flush_i[0] is dropped; empty-stage flush not counted
      flush = 4'b0001;
      drive(1'b1, 16'h001C);
      #1 check("drop.ready", 64'(in_ready), 64'(1));
      tick();
      flush = '0;
      check("drop.valid", 64'(stage_valid), 64'(0));
      check("drop.pc",    64'(stage_pc),    64'(0));
      check("drop.cnt",   64'(flush_cnt),   64'(2));
      drive(1'b1, 16'h001E);
      tick();
      check_stage(0, 1'b1, 16'h001E);
      check_stage(1, 1'b0, 16'h0000);

      // Long stall at stage 0: bubble counter saturation in the narrow instance
      stall = 4'b0001;
      drive(1'b1, 16'h0020);
      repeat (20) tick();
      check("sat.bubble16", 64'(bubble_cnt), 64'(23));
      check("sat.bubble4",  64'(bubble_cnt_s), 64'(15));
      check("sat.flush4",   64'(flush_cnt_s), 64'(2));
      check_stage(0, 1'b1, 16'h001E);
      check_stage(1, 1'b0, 16'h0000);
      stall = '0;
      tick();
      check_stage(0, 1'b1, 16'h0020);
      check_stage(1, 1'b1, 16'h001E);
      check("sat.bubble4_hold", 64'(bubble_cnt_s), 64'(15));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
